// File: rtl/bcd_pkg.sv
// Shared definitions for the packed-BCD multiply/divide unit.
//   state_e       : sequencer states
//   mode_e        : operation select as seen on the mode input
//   BCD_MAX_DIGIT : largest legal BCD nibble
//   bcd_valid()   : checks that every nibble of a zero-extended vector is <= 9
package bcd_pkg;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_e;

  typedef enum logic {MODE_MUL = 1'b0, MODE_DIV = 1'b1} mode_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Widest operand vector the unit can be built with (16 digits, doubled).
  localparam int BCD_MAX_BITS = 128;

  // Callers zero-extend their operand, and zero nibbles are always legal.
  function automatic logic bcd_valid(input logic [BCD_MAX_BITS-1:0] vec);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_BITS / 4; i++) begin
      if (vec[4*i +: 4] > BCD_MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_mult.sv
// Combinational single-digit by multi-digit BCD multiplier.
//   digit : one BCD digit (0..9)
//   vec   : DIGITS-digit packed-BCD operand
//   prod  : (DIGITS+1)-digit packed-BCD product digit * vec
module bcd_digit_mult
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic [3:0]          digit,
  input  logic [4*DIGITS-1:0] vec,
  output logic [4*DIGITS+3:0] prod
);

  // Schoolbook digit-by-digit product. Each partial is at most 9*9+8 = 89,
  // so a 7-bit intermediate and a single decimal carry digit suffice.
  function automatic logic [4*DIGITS+3:0] mul_digit(input logic [3:0] d,
                                                    input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS+3:0] r;
    logic [6:0]          p;
    logic [3:0]          c;
    r = '0;
    c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      p = 7'(d) * 7'(v[4*i +: 4]) + 7'(c);
      r[4*i +: 4] = 4'(p % 7'd10);
      c = 4'(p / 7'd10);
    end
    r[4*DIGITS +: 4] = c;
    return r;
  endfunction

  assign prod = mul_digit(digit, vec);

endmodule

// File: rtl/bcd_muldiv_seq.sv
// Iterative unsigned packed-BCD multiply / divide unit.
//   clk, reset           : clock and synchronous active-high reset
//   start, mode, a, b    : request, 0 = multiply / 1 = divide, operands (taken in IDLE only)
//   busy                 : operation in progress
//   done                 : one-cycle pulse, results and err valid
//   err                  : illegal BCD nibble or divide by zero
//   result_hi/result_lo  : multiply = product high/low digits, divide = remainder/quotient
// Multiply takes DIGITS cycles, divide a fixed 10 cycles per quotient digit.
module bcd_muldiv_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [4*DIGITS-1:0] result_hi,
  output logic [4*DIGITS-1:0] result_lo
);

  localparam int W  = 4 * DIGITS;
  localparam int AW = 8 * DIGITS;
  localparam int RW = 4 * (DIGITS + 1);
  localparam logic [4:0] LAST_IDX = 5'(DIGITS - 1);
  localparam logic [3:0] LAST_SUB = 4'd9;

  state_e        state, state_nxt;
  logic          busy_nxt, done_nxt;
  logic [W-1:0]  a_reg, b_reg, quo, quo_step;
  logic [AW-1:0] acc, acc_sum, partial_sh;
  logic [RW-1:0] rem, rem_shift, rem_diff, rem_step, div_ext;
  logic [W+3:0]  partial;
  logic [4:0]    idx;
  logic [3:0]    sub;
  logic          bad_req, div_ge, last_step;

  // Decimal add over the full accumulator width; the carry out of the top
  // digit is dropped because the product can never exceed 2*DIGITS digits.
  function automatic logic [AW-1:0] bcd_add_acc(input logic [AW-1:0] x, input logic [AW-1:0] y);
    logic [AW-1:0] s;
    logic [4:0]    t;
    logic          c;
    s = '0;
    c = 1'b0;
    for (int i = 0; i < 2 * DIGITS; i++) begin
      t = 5'(x[4*i +: 4]) + 5'(y[4*i +: 4]) + 5'(c);
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    return s;
  endfunction

  // x - y as x + nine's-complement(y) + 1; only used when x >= y, so the
  // ten's-complement wrap leaves the true difference in the low digits.
  function automatic logic [RW-1:0] bcd_sub_rem(input logic [RW-1:0] x, input logic [RW-1:0] y);
    logic [RW-1:0] s;
    logic [4:0]    t;
    logic          c;
    s = '0;
    c = 1'b1;
    for (int i = 0; i < DIGITS + 1; i++) begin
      t = 5'(x[4*i +: 4]) + 5'(BCD_MAX_DIGIT - y[4*i +: 4]) + 5'(c);
      if (t > 5'd9) begin
        t = t + 5'd6;
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      s[4*i +: 4] = t[3:0];
    end
    return s;
  endfunction

  // The multiplier register shifts right, so its low nibble is always the
  // digit currently being worked on.
  bcd_digit_mult #(.DIGITS(DIGITS)) u_digit_mult (
    .digit (b_reg[3:0]),
    .vec   (a_reg),
    .prod  (partial)
  );

  // Operand checks and the datapath values each state would load.
  always_comb begin
    bad_req    = !bcd_valid(BCD_MAX_BITS'(a)) || !bcd_valid(BCD_MAX_BITS'(b))
               || ((mode == MODE_DIV) && (b == '0));
    partial_sh = AW'(partial) << (4 * idx);
    acc_sum    = bcd_add_acc(acc, partial_sh);
    div_ext    = RW'(b_reg);
    div_ge     = (rem >= div_ext);
    rem_diff   = bcd_sub_rem(rem, div_ext);
    rem_shift  = {rem[RW-5:0], a_reg[W-1 -: 4]};
    rem_step   = div_ge ? rem_diff : rem;
    quo_step   = div_ge ? (quo + W'(1)) : quo;
    last_step  = ((state == MUL) && (idx == LAST_IDX))
              || ((state == DIV) && (idx == LAST_IDX) && (sub == LAST_SUB));
  end

  // State register, plus the registered busy/done decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic. A rejected request still passes through FIN so the
  // requester always sees exactly one done pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_req)                state_nxt = FIN;
          else if (mode == MODE_DIV)  state_nxt = DIV;
          else                        state_nxt = MUL;
        end
      end
      MUL, DIV: if (last_step) state_nxt = FIN;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Output decode, computed from the next state so the flops above line up
  // with the state they describe.
  always_comb begin
    busy_nxt = (state_nxt == MUL) || (state_nxt == DIV);
    done_nxt = (state_nxt == FIN);
  end

  // Datapath. Results are cleared on acceptance and reloaded on the edge
  // that enters FIN, then hold until the next accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      rem       <= '0;
      quo       <= '0;
      idx       <= '0;
      sub       <= '0;
      err       <= 1'b0;
      result_hi <= '0;
      result_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            acc       <= '0;
            rem       <= '0;
            quo       <= '0;
            idx       <= '0;
            sub       <= '0;
            err       <= bad_req;
            result_hi <= '0;
            result_lo <= '0;
          end
        end
        MUL: begin
          acc   <= acc_sum;
          b_reg <= b_reg >> 4;
          idx   <= idx + 5'd1;
          if (last_step) {result_hi, result_lo} <= acc_sum;
        end
        DIV: begin
          // Sub-step 0 brings down the next dividend digit; sub-steps 1..9
          // each subtract the divisor at most once, fixing the latency.
          if (sub == 4'd0) begin
            rem   <= rem_shift;
            a_reg <= a_reg << 4;
            quo   <= quo << 4;
          end else begin
            rem <= rem_step;
            quo <= quo_step;
          end
          if (sub == LAST_SUB) begin
            sub <= 4'd0;
            idx <= idx + 5'd1;
          end else begin
            sub <= sub + 4'd1;
          end
          if (last_step) begin
            result_lo <= quo_step;
            result_hi <= rem_step[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
